// File: rtl/orion_2ph_sync_rx_pkg.sv
// Shared constants and sizing helpers for the orion 2-phase receive boundary.
// Phase encodings are here so that the sender and receiver agree on the reset phase.
package orion_2ph_sync_rx_pkg;

    localparam logic PHASE_LOW  = 1'b0;
    localparam logic PHASE_HIGH = 1'b1;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_DEPTH       = 2;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/orion_2ph_sync_rx_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; all flops reset to INIT
// so that a freshly reset chain never shows a phase change the sender did not make.
module orion_2ph_sync_rx_sync_ff
    import orion_2ph_sync_rx_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter logic        INIT   = PHASE_LOW
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {STAGES{INIT}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/orion_2ph_sync_rx.sv
// Clocked receiver for a transition-signalled bundled-data channel: synchronizes the
// request phase, captures the bundled word into a small FIFO and returns the ack phase.
module orion_2ph_sync_rx
    import orion_2ph_sync_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 2,
    parameter logic        P_INIT      = PHASE_LOW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_req,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ack,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned LVL_W = level_width(DEPTH);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if ((DEPTH < MIN_DEPTH) || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic              req_s;
    logic              ack_q;
    logic              pending;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    orion_2ph_sync_rx_sync_ff #(
        .STAGES (SYNC_STAGES),
        .INIT   (P_INIT)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_req),
        .q     (req_s)
    );

    // A token is outstanding whenever the synchronized request phase differs from ack.
    assign pending = req_s ^ ack_q;
    // Full looks only at the registered level, so a same-cycle pop never frees a slot.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push    = pending & ~full;
    assign pop     = ~empty & out_ready;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q   <= P_INIT;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                ack_q  <= ~ack_q;
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    assign in_ack    = ack_q;
    assign out_valid = ~empty;
    assign out_data  = mem_q[rptr_q];
    assign level     = level_q;

    level_bounded: assert property (@(posedge clk) disable iff (reset)
        level_q <= LVL_W'(DEPTH));

endmodule
